// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - golden-model checker comparing ALU r/zero/ovf against a LATENCY-delayed expectation
// Define ALU_CHK_CAPTURE_EN to add cap_a/cap_b/cap_ctrl/cap_r capture of the first mismatch.
module alu_result_checker #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       ctrl,
   input  logic [WIDTH-1:0] r,
   input  logic             zero,
   input  logic             ovf,
   input  logic             clear,
   output logic [CNT_W-1:0] chk_count,
   output logic [CNT_W-1:0] err_count,
   output logic             mismatch,
   output logic             err_flag,
   output logic [1:0]       state
`ifdef ALU_CHK_CAPTURE_EN
   ,
   output logic [WIDTH-1:0] cap_a,
   output logic [WIDTH-1:0] cap_b,
   output logic [1:0]       cap_ctrl,
   output logic [WIDTH-1:0] cap_r
`endif
);

   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FAIL = 2'b10
   } state_t;

   state_t state_q;

   logic [WIDTH-1:0] exp_r;
   logic             exp_zero;
   logic             exp_ovf;

   logic [LATENCY-1:0] p_v;
   logic [WIDTH-1:0]   p_r [LATENCY];
   logic [LATENCY-1:0] p_z;
   logic [LATENCY-1:0] p_o;

   logic cmp_valid;
   logic cmp_fail;

   always_comb begin
      exp_r   = '0;
      exp_ovf = 1'b0;
      case (ctrl)
         2'b00: begin
            exp_r   = a + b;
            exp_ovf = (a[MSB] == b[MSB]) && (exp_r[MSB] != a[MSB]);
         end
         2'b01: begin
            exp_r   = a - b;
            exp_ovf = (a[MSB] != b[MSB]) && (exp_r[MSB] != a[MSB]);
         end
         2'b10: exp_r = a & b;
         default: exp_r = a | b;
      endcase
      exp_zero = (exp_r == '0);
   end

   // Only the valid bits need reset/clear; payload is qualified by them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_v <= '0;
      end else if (clear) begin
         p_v <= '0;
      end else begin
         p_v[0] <= in_valid;
         for (int k = 1; k < LATENCY; k++) begin
            p_v[k] <= p_v[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      p_r[0] <= exp_r;
      p_z[0] <= exp_zero;
      p_o[0] <= exp_ovf;
      for (int k = 1; k < LATENCY; k++) begin
         p_r[k] <= p_r[k-1];
         p_z[k] <= p_z[k-1];
         p_o[k] <= p_o[k-1];
      end
   end

`ifdef ALU_CHK_CAPTURE_EN
   logic [WIDTH-1:0] p_a [LATENCY];
   logic [WIDTH-1:0] p_b [LATENCY];
   logic [1:0]       p_c [LATENCY];

   always_ff @(posedge clk) begin
      p_a[0] <= a;
      p_b[0] <= b;
      p_c[0] <= ctrl;
      for (int k = 1; k < LATENCY; k++) begin
         p_a[k] <= p_a[k-1];
         p_b[k] <= p_b[k-1];
         p_c[k] <= p_c[k-1];
      end
   end
`endif

   // A compare on the clear edge is dropped, so clear gates it here.
   assign cmp_valid = p_v[LATENCY-1] & ~clear;
   assign cmp_fail  = cmp_valid & ((r != p_r[LATENCY-1]) |
                                   (zero != p_z[LATENCY-1]) |
                                   (ovf != p_o[LATENCY-1]));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         chk_count <= '0;
         err_count <= '0;
         mismatch  <= 1'b0;
         err_flag  <= 1'b0;
      end else if (clear) begin
         state_q   <= IDLE;
         chk_count <= '0;
         err_count <= '0;
         mismatch  <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         mismatch <= cmp_fail;
         if (cmp_valid && (chk_count != '1)) begin
            chk_count <= chk_count + CNT_W'(1);
         end
         if (cmp_fail) begin
            err_flag <= 1'b1;
            if (err_count != '1) begin
               err_count <= err_count + CNT_W'(1);
            end
         end
         case (state_q)
            IDLE: begin
               if (cmp_fail) begin
                  state_q <= FAIL;
               end else if (in_valid) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (cmp_fail) begin
                  state_q <= FAIL;
               end
            end
            FAIL: state_q <= FAIL;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state = state_q;

`ifdef ALU_CHK_CAPTURE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_a    <= '0;
         cap_b    <= '0;
         cap_ctrl <= '0;
         cap_r    <= '0;
      end else if (clear) begin
         cap_a    <= '0;
         cap_b    <= '0;
         cap_ctrl <= '0;
         cap_r    <= '0;
      end else if (cmp_fail && !err_flag) begin
         cap_a    <= p_a[LATENCY-1];
         cap_b    <= p_b[LATENCY-1];
         cap_ctrl <= p_c[LATENCY-1];
         cap_r    <= r;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - scoreboard bench for alu_result_checker at LATENCY=1/CNT_W=32 and LATENCY=3/CNT_W=4
module tb_alu_result_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv = 0, z = 0, o = 0, clr = 0;
   logic [31:0] a = 0, b = 0, r = 0;
   logic [1:0]  c = 0;
   logic [31:0] chk, err;
   logic        mm, flag;
   logic [1:0]  st;

   logic        iv3 = 0, z3 = 0, o3 = 0, clr3 = 0;
   logic [31:0] a3 = 0, b3 = 0, r3 = 0;
   logic [1:0]  c3 = 0;
   logic [3:0]  chk3, err3;
   logic        mm3, flag3;
   logic [1:0]  st3;

`ifdef ALU_CHK_CAPTURE_EN
   logic [31:0] cap_a, cap_b, cap_r, cap_a3, cap_b3, cap_r3;
   logic [1:0]  cap_c, cap_c3;
`endif

   alu_result_checker #(.WIDTH(32), .LATENCY(1), .CNT_W(32)) dut (
      .clk(clk), .reset(rst), .in_valid(iv), .a(a), .b(b), .ctrl(c),
      .r(r), .zero(z), .ovf(o), .clear(clr),
      .chk_count(chk), .err_count(err), .mismatch(mm), .err_flag(flag), .state(st)
`ifdef ALU_CHK_CAPTURE_EN
      , .cap_a(cap_a), .cap_b(cap_b), .cap_ctrl(cap_c), .cap_r(cap_r)
`endif
   );

   alu_result_checker #(.WIDTH(32), .LATENCY(3), .CNT_W(4)) dut3 (
      .clk(clk), .reset(rst), .in_valid(iv3), .a(a3), .b(b3), .ctrl(c3),
      .r(r3), .zero(z3), .ovf(o3), .clear(clr3),
      .chk_count(chk3), .err_count(err3), .mismatch(mm3), .err_flag(flag3), .state(st3)
`ifdef ALU_CHK_CAPTURE_EN
      , .cap_a(cap_a3), .cap_b(cap_b3), .cap_ctrl(cap_c3), .cap_r(cap_r3)
`endif
   );

   int total = 0;
   int bad = 0;
   bit exp_q[$];
   bit e;
   int prev_chk = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every compare (chk_count step) pops one expected mismatch bit.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_chk = 0;
      end else begin
         if (chk == prev_chk + 1) begin
            if (exp_q.size() == 0) begin
               check("unexpected compare", chk, prev_chk);
            end else begin
               e = exp_q.pop_front();
               check("mismatch pulse", mm, e);
            end
         end else begin
            check("idle mismatch", mm, 0);
         end
         prev_chk = chk;
      end
   end

   task automatic op1(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] tc,
                      input logic [31:0] tr, input logic tz, input logic to, input bit efail);
      @(negedge clk);
      iv = 1; a = ta; b = tb; c = tc;
      exp_q.push_back(efail);
      @(negedge clk);
      iv = 0; r = tr; z = tz; o = to;
      @(negedge clk);
   endtask

   task automatic pulse_clear1();
      @(negedge clk);
      clr = 1;
      @(negedge clk);
      clr = 0;
   endtask

   logic [31:0] t3_a [3] = '{32'd5, 32'd10, 32'hFF};
   logic [31:0] t3_b [3] = '{32'd7, 32'd3, 32'h0F};
   logic [1:0]  t3_c [3] = '{2'b00, 2'b01, 2'b10};
   logic [31:0] t3_r [3] = '{32'd12, 32'd7, 32'h0F};

   task automatic run3(input int shift);
      int idx;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         iv3 = (i < 3);
         if (i < 3) begin
            a3 = t3_a[i]; b3 = t3_b[i]; c3 = t3_c[i];
         end
         idx = i - 3 + shift;
         if (idx >= 0 && idx < 3) r3 = t3_r[idx];
         else r3 = 0;
         z3 = 0; o3 = 0;
      end
      @(negedge clk);
      r3 = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset chk", chk, 0);
      check("reset err", err, 0);
      check("reset flag", flag, 0);
      check("reset mm", mm, 0);
      check("reset state", st, 2'b00);
      rst = 0;

      op1(32'd5, 32'd7, 2'b00, 32'd12, 0, 0, 0);
      check("add pass chk", chk, 1);
      check("add pass err", err, 0);
      check("add pass state", st, 2'b01);

      op1(32'h7FFFFFFF, 32'd1, 2'b00, 32'h80000000, 0, 0, 1);
      check("ovf fail err", err, 1);
      check("ovf fail chk", chk, 2);
      check("ovf fail flag", flag, 1);
      check("ovf fail state", st, 2'b10);
`ifdef ALU_CHK_CAPTURE_EN
      check("cap_a", cap_a, 32'h7FFFFFFF);
      check("cap_ctrl", cap_c, 2'b00);
      check("cap_r", cap_r, 32'h80000000);
`endif
      @(negedge clk);
      check("mm one cycle", mm, 0);

      pulse_clear1();
      check("clear chk", chk, 0);
      check("clear err", err, 0);
      check("clear flag", flag, 0);
      check("clear state", st, 2'b00);

      op1(32'h1234, 32'h1234, 2'b01, 32'd0, 1, 0, 0);
      op1(32'h1234, 32'h1234, 2'b01, 32'd0, 0, 0, 1);
      op1(32'd1, 32'd1, 2'b00, 32'd2, 0, 0, 0);
      check("sticky fail state", st, 2'b10);
      check("sticky chk", chk, 3);
      check("sticky err", err, 1);
`ifdef ALU_CHK_CAPTURE_EN
      check("cap_a sub", cap_a, 32'h1234);
      check("cap_b sub", cap_b, 32'h1234);
      check("cap_ctrl sub", cap_c, 2'b01);
      check("cap_r sub", cap_r, 32'd0);
`endif

      pulse_clear1();
      op1(32'h80000000, 32'd1, 2'b01, 32'h7FFFFFFF, 0, 1, 0);
      op1(32'h0000F0F0, 32'h00000FF0, 2'b10, 32'h000000F0, 0, 0, 0);
      op1(32'h0000F0F0, 32'h00000FF0, 2'b11, 32'h0000FFF0, 0, 0, 0);
      op1(32'h000000F0, 32'h0000000F, 2'b10, 32'd0, 1, 0, 0);
      op1(32'hFFFFFFFF, 32'd1, 2'b00, 32'd0, 1, 0, 0);
      op1(32'd0, 32'd1, 2'b01, 32'hFFFFFFFF, 0, 0, 0);
      op1(32'h40000000, 32'h40000000, 2'b00, 32'h80000000, 0, 1, 0);
      check("passes keep run", st, 2'b01);
      op1(32'hFFFF, 32'hFFFF, 2'b10, 32'hFFFF, 0, 1, 1);
      check("logic ovf chk", chk, 8);
      check("logic ovf err", err, 1);

      pulse_clear1();
      @(negedge clk);
      clr = 1; iv = 1; a = 1; b = 1; c = 2'b00;
      @(negedge clk);
      clr = 0; iv = 0; r = 2; z = 0; o = 0;
      @(negedge clk);
      check("iv on clear state", st, 2'b00);
      check("iv on clear chk", chk, 0);

      @(negedge clk);
      iv = 1; a = 3; b = 4; c = 2'b00;
      @(negedge clk);
      iv = 0; clr = 1; r = 7;
      @(negedge clk);
      clr = 0;
      @(negedge clk);
      check("inflight clear chk", chk, 0);
      check("inflight clear state", st, 2'b00);

      @(negedge clk);
      iv = 1; a = 32'h7FFFFFFF; b = 1; c = 2'b00;
      @(negedge clk);
      a = 2; b = 2; r = 32'h80000000; z = 0; o = 0;
      @(posedge clk);
      #2 rst = 1;
      #1;
      check("async chk", chk, 0);
      check("async err", err, 0);
      check("async flag", flag, 0);
      check("async mm", mm, 0);
      check("async state", st, 2'b00);
      iv = 0;
      @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);
      check("post reset no compare", chk, 0);

      run3(0);
      check("lat3 chk", chk3, 3);
      check("lat3 err", err3, 0);
      check("lat3 state", st3, 2'b01);
      run3(1);
      check("lat3 early chk", chk3, 6);
      check("lat3 early err", err3, 3);
      check("lat3 early state", st3, 2'b10);

      @(negedge clk); clr3 = 1;
      @(negedge clk); clr3 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         iv3 = 1; a3 = 0; b3 = 0; c3 = 2'b00; r3 = 0; z3 = 0; o3 = 0;
      end
      @(negedge clk);
      iv3 = 0;
      repeat (4) @(negedge clk);
      check("sat chk", chk3, 4'hF);
      check("sat err", err3, 4'hF);
      check("sat flag", flag3, 1);

      @(negedge clk); clr3 = 1;
      @(negedge clk); clr3 = 0; iv3 = 1; a3 = 1; b3 = 1; c3 = 2'b00;
      @(negedge clk); a3 = 2; b3 = 2;
      @(negedge clk); iv3 = 0; clr3 = 1; r3 = 0; z3 = 0;
      @(negedge clk); clr3 = 0;
      repeat (5) @(negedge clk);
      check("lat3 clear chk", chk3, 0);
      check("lat3 clear err", err3, 0);
      check("lat3 clear state", st3, 2'b00);

      check("scoreboard drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
